// File: rtl/display_pkg.sv
// display_pkg: shared constants for the pulse counter display.
//   - REFRESH_DIV_DEFAULT : default per-digit dwell in clk_in cycles
//   - SEG_0 .. SEG_F      : active-low {a,b,c,d,e,f,g} hex glyphs
//   - SEG_BLANK           : all segments off
package display_pkg;

  localparam int REFRESH_DIV_DEFAULT = 50000;

  localparam logic [6:0] SEG_0     = 7'b0000001;
  localparam logic [6:0] SEG_1     = 7'b1001111;
  localparam logic [6:0] SEG_2     = 7'b0010010;
  localparam logic [6:0] SEG_3     = 7'b0000110;
  localparam logic [6:0] SEG_4     = 7'b1001100;
  localparam logic [6:0] SEG_5     = 7'b0100100;
  localparam logic [6:0] SEG_6     = 7'b0100000;
  localparam logic [6:0] SEG_7     = 7'b0001111;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0000100;
  localparam logic [6:0] SEG_A     = 7'b0001000;
  localparam logic [6:0] SEG_B     = 7'b1100000;
  localparam logic [6:0] SEG_C     = 7'b0110001;
  localparam logic [6:0] SEG_D     = 7'b1000010;
  localparam logic [6:0] SEG_E     = 7'b0110000;
  localparam logic [6:0] SEG_F     = 7'b0111000;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

endpackage

// File: rtl/hex_to_7seg.sv
// hex_to_7seg: combinational nibble to active-low seven-segment decode.
//   nib_i [3:0] : hex digit
//   seg_o [6:0] : segments {a,b,c,d,e,f,g}, 0 = lit
module hex_to_7seg
  import display_pkg::*;
(
  input  logic [3:0] nib_i,
  output logic [6:0] seg_o
);

  always_comb begin
    seg_o = SEG_BLANK;
    case (nib_i)
      4'h0: seg_o = SEG_0;
      4'h1: seg_o = SEG_1;
      4'h2: seg_o = SEG_2;
      4'h3: seg_o = SEG_3;
      4'h4: seg_o = SEG_4;
      4'h5: seg_o = SEG_5;
      4'h6: seg_o = SEG_6;
      4'h7: seg_o = SEG_7;
      4'h8: seg_o = SEG_8;
      4'h9: seg_o = SEG_9;
      4'hA: seg_o = SEG_A;
      4'hB: seg_o = SEG_B;
      4'hC: seg_o = SEG_C;
      4'hD: seg_o = SEG_D;
      4'hE: seg_o = SEG_E;
      4'hF: seg_o = SEG_F;
      default: seg_o = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/pulse_count_display.sv
// pulse_count_display: synchronizes debounced inc/dec/clr requests, keeps a
// 16-bit wrapping event count and scans it onto a 4-digit common-anode
// seven-segment display.
//   clk_in        : system clock
//   reset         : synchronous, active-high
//   inc_in/dec_in : asynchronous one-shots, each rising edge counts once
//   clr_in        : asynchronous level clear, highest priority after reset
//   count_out     : current count
//   an            : digit enables, active-low, an[0] = least significant digit
//   seg           : active-low segments {a..g} for the lit digit
module pulse_count_display
  import display_pkg::*;
#(
  parameter int REFRESH_DIV = REFRESH_DIV_DEFAULT
) (
  input  logic        clk_in,
  input  logic        reset,
  input  logic        inc_in,
  input  logic        dec_in,
  input  logic        clr_in,
  output logic [15:0] count_out,
  output logic [3:0]  an,
  output logic [6:0]  seg
);

  localparam logic [15:0] RCNT_LAST = 16'(REFRESH_DIV - 1);

  // [0] = first sync flop, [1] = second sync flop, [2] = edge-detect flop
  logic [2:0]  inc_s_q, dec_s_q;
  logic [1:0]  clr_s_q;
  // Counts edges since reset release; events stay masked until the edge
  // flop holds a real synchronized level, so a pulse that straddles reset
  // is never mistaken for a new edge.
  logic [1:0]  arm_q;
  logic [15:0] count_q, count_d;
  logic [15:0] rcnt_q;
  logic [1:0]  dig_q;
  logic [3:0]  an_q;
  logic [6:0]  seg_q;
  logic [3:0]  nib;
  logic [6:0]  seg_d;
  logic        armed, inc_evt, dec_evt, clr_s;

  assign armed   = (arm_q == 2'd3);
  assign inc_evt = armed & inc_s_q[1] & ~inc_s_q[2];
  assign dec_evt = armed & dec_s_q[1] & ~dec_s_q[2];
  assign clr_s   = clr_s_q[1];

  always_comb begin
    count_d = count_q;
    if (clr_s)                    count_d = 16'h0000;
    else if (inc_evt && dec_evt)  count_d = count_q;
    else if (inc_evt)             count_d = count_q + 16'd1;
    else if (dec_evt)             count_d = count_q - 16'd1;
  end

  always_comb begin
    nib = count_q[3:0];
    case (dig_q)
      2'd0: nib = count_q[3:0];
      2'd1: nib = count_q[7:4];
      2'd2: nib = count_q[11:8];
      2'd3: nib = count_q[15:12];
      default: nib = count_q[3:0];
    endcase
  end

  hex_to_7seg u_dec (
    .nib_i (nib),
    .seg_o (seg_d)
  );

  always_ff @(posedge clk_in) begin
    if (reset) begin
      inc_s_q <= '0;
      dec_s_q <= '0;
      clr_s_q <= '0;
      arm_q   <= '0;
      count_q <= '0;
      rcnt_q  <= '0;
      dig_q   <= '0;
      an_q    <= 4'b1110;
      seg_q   <= SEG_0;
    end else begin
      inc_s_q <= {inc_s_q[1:0], inc_in};
      dec_s_q <= {dec_s_q[1:0], dec_in};
      clr_s_q <= {clr_s_q[0], clr_in};
      if (!armed) arm_q <= arm_q + 2'd1;
      count_q <= count_d;
      if (rcnt_q == RCNT_LAST) begin
        rcnt_q <= '0;
        dig_q  <= dig_q + 2'd1;
      end else begin
        rcnt_q <= rcnt_q + 16'd1;
      end
      // an and seg are loaded from the same dig_q so they always pair up.
      an_q  <= ~(4'b0001 << dig_q);
      seg_q <= seg_d;
    end
  end

  assign count_out = count_q;
  assign an        = an_q;
  assign seg       = seg_q;

endmodule
